// File: rtl/food_eat_ctrl.sv
// Purpose: per-frame pellet-eat controller. It looks up the food tile under Pac-Man, strobes a clear for that tile, and updates the BCD score and the pellet count.
// Latency: is_food_eaten is high 3 cycles after the frame edge pulse (fe); score and count change 4 cycles after fe.
// Backpressure: none. A frame edge that arrives while a lookup is in flight, or after the level is cleared, is dropped.
//
// Ports:
//   Clk, Reset           system clock; asynchronous active-low reset
//   frame_clk            vsync level from another clock domain; one lookup per rising edge
//   game_reset           synchronous level restart; reloads the pellets and keeps the score
//   Ball_X/Y_Pos_out     Pac-Man pixel position
//   food_bit / food_addr food-map read port (food_bit 0 = pellet present)
//   is_food_eaten        one-cycle clear strobe for the entry at food_addr
//   score_bcd            4-digit packed BCD score, saturating at 9999
//   pellets_left         remaining pellets; level_clear is high while this is 0
module food_eat_ctrl #(
    parameter int COLS         = 20,
    parameter int ROWS         = 11,
    parameter int TILE_SHIFT   = 5,
    parameter int PELLETS_INIT = 150,
    parameter int POINTS       = 10
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic        game_reset,
    input  logic [9:0]  Ball_X_Pos_out,
    input  logic [9:0]  Ball_Y_Pos_out,
    input  logic        food_bit,
    output logic [7:0]  food_addr,
    output logic        is_food_eaten,
    output logic [15:0] score_bcd,
    output logic [7:0]  pellets_left,
    output logic        level_clear
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        READ  = 3'd2,
        EAT   = 3'd3,
        SCORE = 3'd4
    } state_t;

    // POINTS split into BCD digits once, at elaboration time
    localparam logic [3:0] PT_ONES = 4'(POINTS % 10);
    localparam logic [3:0] PT_TENS = 4'(POINTS / 10);

    state_t      state;
    logic        oob;
    logic        eat_q;

    // ------------------------------------------------------------------
    // frame_clk synchronizer and rising-edge detector.
    // fclk_hist is the previous synchronized sample. It is held at 1 until
    // sync_vld shows that fclk_s2 carries a real sample. Without this, a
    // frame_clk that is already high when reset is released would look
    // like a new rising edge.
    // ------------------------------------------------------------------
    logic       fclk_s1, fclk_s2, fclk_hist;
    logic [1:0] sync_vld;
    logic       fe;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            fclk_s1   <= 1'b0;
            fclk_s2   <= 1'b0;
            fclk_hist <= 1'b1;
            sync_vld  <= 2'b00;
        end else begin
            fclk_s1   <= frame_clk;
            fclk_s2   <= fclk_s1;
            sync_vld  <= {sync_vld[0], 1'b1};
            fclk_hist <= sync_vld[1] ? fclk_s2 : 1'b1;
        end
    end

    assign fe = fclk_s2 & ~fclk_hist;

    // ------------------------------------------------------------------
    // Tile lookup, from the current ball position
    // ------------------------------------------------------------------
    logic [9:0] col, row;
    logic [7:0] tile_addr;
    logic       tile_oob;

    assign col       = Ball_X_Pos_out >> TILE_SHIFT;
    assign row       = Ball_Y_Pos_out >> TILE_SHIFT;
    // The address is truncated to the 8-bit port. Out-of-range tiles can
    // alias a real entry, but the oob flag prevents them from being eaten.
    assign tile_addr = 8'((32'(row) * 32'(COLS)) + 32'(col));
    assign tile_oob  = (col >= 10'(COLS)) || (row >= 10'(ROWS));

    // ------------------------------------------------------------------
    // BCD score adder, with saturation on carry out of the top digit
    // ------------------------------------------------------------------
    function automatic logic [4:0] bcd_digit_add(input logic [3:0] a,
                                                 input logic [3:0] b,
                                                 input logic       cin);
        logic [4:0] s;
        s = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        // Adding 6 modulo 16 gives s - 10 for sums from 10 to 19
        if (s > 5'd9) return {1'b1, s[3:0] + 4'd6};
        else          return {1'b0, s[3:0]};
    endfunction

    logic [3:0]  n0, n1, n2, n3;
    logic        c0, c1, c2, c3;
    logic [15:0] score_next;
    logic [7:0]  pellets_next;

    always_comb begin
        {c0, n0} = bcd_digit_add(score_bcd[3:0],   PT_ONES, 1'b0);
        {c1, n1} = bcd_digit_add(score_bcd[7:4],   PT_TENS, c0);
        {c2, n2} = bcd_digit_add(score_bcd[11:8],  4'd0,    c1);
        {c3, n3} = bcd_digit_add(score_bcd[15:12], 4'd0,    c2);
        score_next = c3 ? 16'h9999 : {n3, n2, n1, n0};
    end

    assign pellets_next = (pellets_left == 8'd0) ? 8'd0 : pellets_left - 8'd1;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state        <= IDLE;
            food_addr    <= 8'd0;
            oob          <= 1'b0;
            eat_q        <= 1'b0;
            score_bcd    <= 16'h0000;
            pellets_left <= 8'(PELLETS_INIT);
            level_clear  <= 1'b0;
        end else if (game_reset) begin
            state        <= IDLE;
            eat_q        <= 1'b0;
            pellets_left <= 8'(PELLETS_INIT);
            level_clear  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    eat_q <= 1'b0;
                    if (fe && !level_clear) state <= ADDR;
                end
                ADDR: begin
                    food_addr <= tile_addr;
                    oob       <= tile_oob;
                    state     <= READ;
                end
                READ: begin
                    if (!food_bit && !oob) begin
                        eat_q <= 1'b1;
                        state <= EAT;
                    end else begin
                        state <= IDLE;
                    end
                end
                EAT: begin
                    // The update is committed as the FSM enters SCORE, so the
                    // new score, count and level_clear are visible during the
                    // SCORE cycle (fe + 4).
                    eat_q        <= 1'b0;
                    score_bcd    <= score_next;
                    pellets_left <= pellets_next;
                    level_clear  <= (pellets_next == 8'd0);
                    state        <= SCORE;
                end
                SCORE: begin
                    state <= IDLE;
                end
                default: begin
                    eat_q <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // The strobe is gated by game_reset so that a restart arriving during
    // EAT also suppresses the strobe in that same cycle.
    assign is_food_eaten = eat_q & ~game_reset;

endmodule

// File: tb/tb_food_eat_ctrl.sv
module tb_food_eat_ctrl;

    localparam int COLS  = 20;
    localparam int ROWS  = 11;
    localparam int TS    = 5;
    localparam int PINIT = 2;
    localparam int PTS   = 5;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        frame_clk;
    logic        game_reset;
    logic [9:0]  bx, by;
    logic        food_bit;
    logic [7:0]  food_addr;
    logic        is_food_eaten;
    logic [15:0] score_bcd;
    logic [7:0]  pellets_left;
    logic        level_clear;

    food_eat_ctrl #(
        .COLS(COLS), .ROWS(ROWS), .TILE_SHIFT(TS),
        .PELLETS_INIT(PINIT), .POINTS(PTS)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .frame_clk(frame_clk),
        .game_reset(game_reset),
        .Ball_X_Pos_out(bx),
        .Ball_Y_Pos_out(by),
        .food_bit(food_bit),
        .food_addr(food_addr),
        .is_food_eaten(is_food_eaten),
        .score_bcd(score_bcd),
        .pellets_left(pellets_left),
        .level_clear(level_clear)
    );

    always #5 Clk = ~Clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: decimal score, pellet count, clear flag, current address
    int         m_score;
    int         m_pel;
    bit         m_clear;
    logic [7:0] m_addr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic check_state(input string tag);
        chk({tag, "_score"},  32'(score_bcd),    32'(to_bcd(m_score)));
        chk({tag, "_pellet"}, 32'(pellets_left), 32'(m_pel));
        chk({tag, "_clear"},  32'(level_clear),  32'(m_clear));
        chk({tag, "_addr"},   32'(food_addr),    32'(m_addr));
    endtask

    task automatic do_game_reset();
        @(negedge Clk);
        game_reset = 1'b1;
        @(negedge Clk);
        game_reset = 1'b0;
        m_pel   = PINIT;
        m_clear = 1'b0;
        check_state("grst");
    endtask

    // abort: 0 = none, 1 = game_reset during EAT, 2 = Reset during EAT
    task automatic do_frame(input logic [9:0] x, input logic [9:0] y,
                            input logic fb, input int abort);
        int         col, row;
        logic [7:0] new_addr;
        bit         oob, eats;
        col      = int'(x) >> TS;
        row      = int'(y) >> TS;
        oob      = (col >= COLS) || (row >= ROWS);
        new_addr = 8'((row * COLS + col) % 256);
        eats     = !m_clear && !oob && !fb;

        @(negedge Clk);
        bx = x; by = y; food_bit = fb; frame_clk = 1'b1;
        // fe is high in the cycle after posedge 2, EAT follows posedge 5,
        // and SCORE follows posedge 6
        for (int i = 1; i <= 7; i++) begin
            @(posedge Clk);
            if (i == 5 && eats && abort != 0) begin
                #1;
                if (abort == 1) game_reset = 1'b1;
                else            Reset      = 1'b0;
                #1;
                chk("abort_strobe", 32'(is_food_eaten), 32'd0);
                if (abort == 1) begin
                    @(posedge Clk);
                    @(negedge Clk);
                    game_reset = 1'b0;
                    m_pel   = PINIT;
                    m_clear = 1'b0;
                    check_state("grst_abort");
                end else begin
                    m_score = 0;
                    m_pel   = PINIT;
                    m_clear = 1'b0;
                    m_addr  = 8'd0;
                    check_state("rst_abort");
                    @(negedge Clk);
                    @(negedge Clk);
                    Reset = 1'b1;   // frame_clk is still high at release
                    for (int k = 0; k < 8; k++) begin
                        @(negedge Clk);
                        chk("rst_no_fe", 32'(is_food_eaten), 32'd0);
                    end
                    check_state("rst_after");
                end
                break;
            end
            @(negedge Clk);
            if (i == 4 && !m_clear) m_addr = new_addr;
            chk("strobe", 32'(is_food_eaten), 32'(i == 5 && eats));
            chk("addr",   32'(food_addr),     32'(m_addr));
            if (i == 6 && eats) begin
                m_score = (m_score + PTS > 9999) ? 9999 : m_score + PTS;
                if (m_pel > 0) m_pel--;
                if (m_pel == 0) m_clear = 1'b1;
            end
            if (i >= 5) check_state("frame");
        end
        frame_clk = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            chk("tail_strobe", 32'(is_food_eaten), 32'd0);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b0; frame_clk = 1'b0; game_reset = 1'b0;
        food_bit = 1'b1; bx = '0; by = '0;
        m_score = 0; m_pel = PINIT; m_clear = 1'b0; m_addr = 8'd0;

        repeat (3) @(negedge Clk);
        check_state("reset");
        chk("reset_strobe", 32'(is_food_eaten), 32'd0);
        Reset = 1'b1;
        repeat (3) @(negedge Clk);

        // Directed cases
        do_frame(10'd100, 10'd70,  1'b0, 0);  // basic eat, tile 43
        chk("basic_addr", 32'(food_addr), 32'd43);
        do_frame(10'd100, 10'd70,  1'b1, 0);  // empty tile
        do_frame(10'd650, 10'd70,  1'b0, 0);  // column 20 is out of bounds
        do_frame(10'd40,  10'd300, 1'b0, 0);  // last pellet -> level clear
        chk("lvl_clear", 32'(level_clear), 32'd1);
        do_frame(10'd100, 10'd70,  1'b0, 0);  // ignored while cleared
        do_game_reset();
        do_frame(10'd200, 10'd100, 1'b0, 1);  // game_reset during EAT
        do_frame(10'd200, 10'd100, 1'b0, 2);  // Reset during EAT

        // Randomized frames
        for (int n = 0; n < 300; n++) begin
            logic [9:0] x, y;
            int ab;
            if (m_clear || ($urandom % 20) == 0) do_game_reset();
            if (($urandom % 10) < 7) begin
                x = 10'($urandom_range(0, COLS * 32 - 1));
                y = 10'($urandom_range(0, ROWS * 32 - 1));
            end else begin
                x = 10'($urandom_range(0, 1023));
                y = 10'($urandom_range(0, 1023));
            end
            ab = (($urandom % 16) == 0) ? int'($urandom_range(1, 2)) : 0;
            do_frame(x, y, 1'($urandom % 3 == 0), ab);
        end

        // Run the score up to saturation, through 95->100, 995->1000 and 9995->9999
        for (int k = 0; k < 2100 && m_score < 9999; k++) begin
            if (m_clear) do_game_reset();
            do_frame(10'd100, 10'd70, 1'b0, 0);
        end
        chk("sat_value", 32'(score_bcd), 32'h9999);
        if (m_clear) do_game_reset();
        do_frame(10'd100, 10'd70, 1'b0, 0);
        chk("sat_hold", 32'(score_bcd), 32'h9999);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
